uart_arbiter: RTL and testbench

Two-master arbiter in front of `uart_buffer`'s byte/word read and write request ports, letting the core (master 0) and the boot/debug loader (master 1) share one UART. Each master sees the same pulse-request / pulse-done protocol `uart_buffer` exposes. The arbiter serialises requests per direction, holds size and data stable while the buffer retries internally, and routes `rdone`/`wdone`/`rdata` back to the owner. The read and write channels are independent and may be busy at the same time.

---
 rtl/uart_arb_pkg.sv | 20 ++
 rtl/uart_arb_channel.sv | 140 ++++++++++++++
 rtl/uart_arbiter.sv | 100 ++++++++++
 tb/tb_uart_arbiter.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the two-master UART arbiter.
package uart_arb_pkg;

    // Per-channel arbitration state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    localparam logic [1:0] SZ_BYTE     = 2'b00;
    localparam logic [1:0] SZ_WORD     = 2'b11;
    localparam int         NUM_MASTERS = 2;

    // Only byte and word transfers are forwarded; other size codes are dropped
    function automatic logic size_legal(input logic [1:0] sz);
        return (sz == SZ_BYTE) || (sz == SZ_WORD);
    endfunction

endpackage

// File: rtl/uart_arb_channel.sv
// One arbitration channel (read or write): request latches, winner selection,
// single-cycle issue and wait-for-done, with per-master done/rdata return.
// The lock input is tied low by the top when UART_ARB_LOCK_EN is not defined.
module uart_arb_channel
    import uart_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
)
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  req,
    input  logic [1:0]  size0,
    input  logic [1:0]  size1,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [1:0]  lock,
    output logic        buf_enable,
    output logic [1:0]  buf_size,
    output logic [31:0] buf_data,
    input  logic [31:0] buf_rdata,
    input  logic        buf_done,
    output logic [1:0]  done,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1
);

    arb_state_t             state_reg;
    logic [NUM_MASTERS-1:0] pend_reg;
    logic                   owner_reg;
    logic                   last_reg;
    logic                   lock_hold_reg;
    logic [1:0]             size_lat_reg [NUM_MASTERS];
    logic [31:0]            data_lat_reg [NUM_MASTERS];
    logic [31:0]            rdata_reg    [NUM_MASTERS];

    logic [1:0]             req_size [NUM_MASTERS];
    logic [31:0]            req_data [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] accept;
    logic                   finish;
    logic                   grant_valid;
    logic                   grant;

    assign req_size[0] = size0;
    assign req_size[1] = size1;
    assign req_data[0] = data0;
    assign req_data[1] = data1;
    assign rdata0      = rdata_reg[0];
    assign rdata1      = rdata_reg[1];

    assign finish = (state_reg == ST_WAIT) && buf_done;

    // A request is taken when that master has nothing pending, or when its
    // pending transfer completes in this very cycle (so a held enable re-arms).
    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_capture
            assign accept[gi] = req[gi] && size_legal(req_size[gi]) &&
                                (!pend_reg[gi] || (finish && (owner_reg == 1'(gi))));
        end
    endgenerate

    // Winner selection: a held lock restricts the grant to the previous owner,
    // otherwise fixed priority or round-robin against the last winner.
    always_comb begin
        grant_valid = 1'b0;
        grant       = 1'b0;
        if (lock_hold_reg && lock[last_reg]) begin
            grant_valid = pend_reg[last_reg];
            grant       = last_reg;
        end else if (pend_reg == 2'b11) begin
            grant_valid = 1'b1;
            grant       = (FIXED_PRIO != 0) ? 1'b0 : ~last_reg;
        end else if (pend_reg != 2'b00) begin
            grant_valid = 1'b1;
            grant       = pend_reg[1];
        end
    end

    // Channel FSM with request latches and registered buffer/master outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= ST_IDLE;
            pend_reg      <= '0;
            owner_reg     <= 1'b0;
            last_reg      <= 1'b1;
            lock_hold_reg <= 1'b0;
            buf_enable    <= 1'b0;
            buf_size      <= SZ_BYTE;
            buf_data      <= '0;
            done          <= '0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                size_lat_reg[i] <= SZ_BYTE;
                data_lat_reg[i] <= '0;
                rdata_reg[i]    <= '0;
            end
        end else begin
            done <= '0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (accept[i]) begin
                    pend_reg[i]     <= 1'b1;
                    size_lat_reg[i] <= req_size[i];
                    data_lat_reg[i] <= req_data[i];
                end
            end
            case (state_reg)
                ST_IDLE: begin
                    if (grant_valid) begin
                        buf_size   <= size_lat_reg[grant];
                        buf_data   <= data_lat_reg[grant];
                        owner_reg  <= grant;
                        buf_enable <= 1'b1;
                        state_reg  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    buf_enable <= 1'b0;
                    state_reg  <= ST_WAIT;
                end
                ST_WAIT: begin
                    // size/data stay put: the buffer retries with the live values
                    if (buf_done) begin
                        done[owner_reg]      <= 1'b1;
                        rdata_reg[owner_reg] <= buf_rdata;
                        if (!accept[owner_reg]) begin
                            pend_reg[owner_reg] <= 1'b0;
                        end
                        last_reg      <= owner_reg;
                        lock_hold_reg <= lock[owner_reg];
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // A done from the buffer outside WAIT has no owner and is dropped
    assert property (@(posedge clk) disable iff (!rstn) buf_done |-> (state_reg == ST_WAIT));

endmodule

// File: rtl/uart_arbiter.sv
// Two-master arbiter in front of uart_buffer: independent read and write
// channels, each serialising requests from the core (m0) and loader (m1).
// Optional feature macro: UART_ARB_LOCK_EN adds m0_lock/m1_lock ownership hold.
module uart_arbiter
    import uart_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
)
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        m0_renable,
    input  logic        m1_renable,
    input  logic [1:0]  m0_rsize,
    input  logic [1:0]  m1_rsize,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        m0_rdone,
    output logic        m1_rdone,
    input  logic        m0_wenable,
    input  logic        m1_wenable,
    input  logic [1:0]  m0_wsize,
    input  logic [1:0]  m1_wsize,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    output logic        m0_wdone,
    output logic        m1_wdone,
`ifdef UART_ARB_LOCK_EN
    input  logic        m0_lock,
    input  logic        m1_lock,
`endif
    output logic        buf_renable,
    output logic [1:0]  buf_rsize,
    input  logic [31:0] buf_rdata,
    input  logic        buf_rdone,
    output logic        buf_wenable,
    output logic [1:0]  buf_wsize,
    output logic [31:0] buf_wdata,
    input  logic        buf_wdone
);

    logic [1:0]  lock_vec;
    logic [1:0]  rd_done;
    logic [1:0]  wr_done;
    logic [31:0] rd_wdata_unused;
    logic [31:0] wr_rdata0_unused;
    logic [31:0] wr_rdata1_unused;

`ifdef UART_ARB_LOCK_EN
    assign lock_vec = {m1_lock, m0_lock};
`else
    assign lock_vec = 2'b00;
`endif

    assign m0_rdone = rd_done[0];
    assign m1_rdone = rd_done[1];
    assign m0_wdone = wr_done[0];
    assign m1_wdone = wr_done[1];

    // Read channel: no write data, returns buffer rdata to the owner
    uart_arb_channel #(.FIXED_PRIO(FIXED_PRIO)) u_rd_channel (
        .clk        (clk),
        .rstn       (rstn),
        .req        ({m1_renable, m0_renable}),
        .size0      (m0_rsize),
        .size1      (m1_rsize),
        .data0      (32'h0),
        .data1      (32'h0),
        .lock       (lock_vec),
        .buf_enable (buf_renable),
        .buf_size   (buf_rsize),
        .buf_data   (rd_wdata_unused),
        .buf_rdata  (buf_rdata),
        .buf_done   (buf_rdone),
        .done       (rd_done),
        .rdata0     (m0_rdata),
        .rdata1     (m1_rdata)
    );

    // Write channel: forwards latched write data, nothing comes back
    uart_arb_channel #(.FIXED_PRIO(FIXED_PRIO)) u_wr_channel (
        .clk        (clk),
        .rstn       (rstn),
        .req        ({m1_wenable, m0_wenable}),
        .size0      (m0_wsize),
        .size1      (m1_wsize),
        .data0      (m0_wdata),
        .data1      (m1_wdata),
        .lock       (lock_vec),
        .buf_enable (buf_wenable),
        .buf_size   (buf_wsize),
        .buf_data   (buf_wdata),
        .buf_rdata  (32'h0),
        .buf_done   (buf_wdone),
        .done       (wr_done),
        .rdata0     (wr_rdata0_unused),
        .rdata1     (wr_rdata1_unused)
    );

endmodule

// File: tb/tb_uart_arbiter.sv
// Directed bench for uart_arbiter: round-robin instance plus a FIXED_PRIO=1
// instance; a small uart_buffer responder runs inside the tick task.
module tb_uart_arbiter;
    import uart_arb_pkg::*;

    logic        clk;
    logic        rstn;
    logic        m0_renable, m1_renable;
    logic [1:0]  m0_rsize, m1_rsize;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_rdone, m1_rdone;
    logic        m0_wenable, m1_wenable;
    logic [1:0]  m0_wsize, m1_wsize;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_wdone, m1_wdone;
    logic        m0_lock, m1_lock;
    logic        buf_renable;
    logic [1:0]  buf_rsize;
    logic [31:0] buf_rdata;
    logic        buf_rdone;
    logic        buf_wenable;
    logic [1:0]  buf_wsize;
    logic [31:0] buf_wdata;
    logic        buf_wdone;

    // fixed-priority instance (read channel exercised only)
    logic        f_m0_renable, f_m1_renable;
    logic [31:0] f_m0_rdata, f_m1_rdata;
    logic        f_m0_rdone, f_m1_rdone;
    logic        f_buf_renable;
    logic [1:0]  f_buf_rsize_unused;
    logic [31:0] f_buf_rdata;
    logic        f_buf_rdone;
    logic        f_wdone0_unused, f_wdone1_unused, f_buf_wenable_unused;
    logic [1:0]  f_buf_wsize_unused;
    logic [31:0] f_buf_wdata_unused;
    logic        f_force;
    logic [31:0] f_ret;

    // buffer responder state
    int          rd_lat, wr_lat, rd_cnt, wr_cnt;
    logic        rd_manual, rd_force;
    logic [31:0] rd_ret;
    logic [31:0] wlog_data [16];
    logic [1:0]  wlog_size [16];
    int          wlog_n;

    int checks;
    int failures;

    uart_arbiter #(.FIXED_PRIO(0)) dut (
        .clk(clk), .rstn(rstn),
        .m0_renable(m0_renable), .m1_renable(m1_renable),
        .m0_rsize(m0_rsize), .m1_rsize(m1_rsize),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .m0_rdone(m0_rdone), .m1_rdone(m1_rdone),
        .m0_wenable(m0_wenable), .m1_wenable(m1_wenable),
        .m0_wsize(m0_wsize), .m1_wsize(m1_wsize),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_wdone(m0_wdone), .m1_wdone(m1_wdone),
`ifdef UART_ARB_LOCK_EN
        .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
        .buf_renable(buf_renable), .buf_rsize(buf_rsize),
        .buf_rdata(buf_rdata), .buf_rdone(buf_rdone),
        .buf_wenable(buf_wenable), .buf_wsize(buf_wsize),
        .buf_wdata(buf_wdata), .buf_wdone(buf_wdone)
    );

    uart_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rstn(rstn),
        .m0_renable(f_m0_renable), .m1_renable(f_m1_renable),
        .m0_rsize(SZ_BYTE), .m1_rsize(SZ_BYTE),
        .m0_rdata(f_m0_rdata), .m1_rdata(f_m1_rdata),
        .m0_rdone(f_m0_rdone), .m1_rdone(f_m1_rdone),
        .m0_wenable(1'b0), .m1_wenable(1'b0),
        .m0_wsize(SZ_BYTE), .m1_wsize(SZ_BYTE),
        .m0_wdata(32'h0), .m1_wdata(32'h0),
        .m0_wdone(f_wdone0_unused), .m1_wdone(f_wdone1_unused),
`ifdef UART_ARB_LOCK_EN
        .m0_lock(1'b0), .m1_lock(1'b0),
`endif
        .buf_renable(f_buf_renable), .buf_rsize(f_buf_rsize_unused),
        .buf_rdata(f_buf_rdata), .buf_rdone(f_buf_rdone),
        .buf_wenable(f_buf_wenable_unused), .buf_wsize(f_buf_wsize_unused),
        .buf_wdata(f_buf_wdata_unused), .buf_wdone(1'b0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle, then play the uart_buffer side for both instances
    task automatic tick();
        @(posedge clk);
        #1;
        buf_rdone   = 1'b0;
        buf_wdone   = 1'b0;
        f_buf_rdone = 1'b0;
        if (!rstn) begin
            rd_cnt   = 0;
            wr_cnt   = 0;
            rd_force = 1'b0;
            f_force  = 1'b0;
        end else begin
            if (rd_force) begin
                buf_rdone = 1'b1;
                buf_rdata = rd_ret;
                rd_force  = 1'b0;
            end else if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    buf_rdone = 1'b1;
                    buf_rdata = rd_ret;
                end
            end else if (buf_renable && !rd_manual) begin
                rd_cnt = rd_lat;
            end
            if (wr_cnt > 0) begin
                wr_cnt--;
                if (wr_cnt == 0) buf_wdone = 1'b1;
            end else if (buf_wenable) begin
                wr_cnt = wr_lat;
                if (wlog_n < 16) begin
                    wlog_data[wlog_n] = buf_wdata;
                    wlog_size[wlog_n] = buf_wsize;
                end
                wlog_n++;
            end
            if (f_force) begin
                f_buf_rdone = 1'b1;
                f_buf_rdata = f_ret;
                f_force     = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if ({buf_renable, buf_wenable, buf_rsize, buf_wsize} !== 6'b0) begin
            failures++;
            $display("FAIL reset_buf_ctrl: got %b expected 000000", {buf_renable, buf_wenable, buf_rsize, buf_wsize});
        end
        checks++;
        if ({m0_rdone, m1_rdone, m0_wdone, m1_wdone} !== 4'b0) begin
            failures++;
            $display("FAIL reset_done: got %b expected 0000", {m0_rdone, m1_rdone, m0_wdone, m1_wdone});
        end
        checks++;
        if (buf_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_wdata: got %h expected 00000000", buf_wdata);
        end
        checks++;
        if ({m0_rdata, m1_rdata} !== 64'h0) begin
            failures++;
            $display("FAIL reset_rdata: got %h expected 0", {m0_rdata, m1_rdata});
        end
        rstn = 1'b1;
        tick();
        $display("txn reset: done");
    endtask

    task automatic test_single_read();
        int   n;
        logic m1_seen;
        logic en_extra;
        rd_ret     = 32'h0000_0041;
        m0_rsize   = SZ_BYTE;
        m0_renable = 1'b1;
        tick();
        m0_renable = 1'b0;
        checks++;
        if (buf_renable !== 1'b0) begin
            failures++;
            $display("FAIL rd_enable_t1: got %b expected 0", buf_renable);
        end
        tick();
        checks++;
        if (buf_renable !== 1'b1) begin
            failures++;
            $display("FAIL rd_enable_t2: got %b expected 1", buf_renable);
        end
        checks++;
        if (buf_rsize !== SZ_BYTE) begin
            failures++;
            $display("FAIL rd_size: got %b expected 00", buf_rsize);
        end
        checks++;
        if (m0_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rd_data_before: got %h expected 00000000", m0_rdata);
        end
        n = 0;
        m1_seen = 1'b0;
        en_extra = 1'b0;
        while (m0_rdone !== 1'b1 && n < 20) begin
            tick();
            n++;
            if (m1_rdone === 1'b1) m1_seen = 1'b1;
            if (buf_renable === 1'b1) en_extra = 1'b1;
        end
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL rd_done_latency: got %0d cycles after enable expected 4", n);
        end
        checks++;
        if (m0_rdata !== 32'h0000_0041) begin
            failures++;
            $display("FAIL rd_data: got %h expected 00000041", m0_rdata);
        end
        checks++;
        if (en_extra !== 1'b0) begin
            failures++;
            $display("FAIL rd_enable_width: got extra enable expected single cycle");
        end
        tick();
        checks++;
        if ({m0_rdone, m1_seen} !== 2'b00) begin
            failures++;
            $display("FAIL rd_done_pulse: got m0_rdone=%b m1_seen=%b expected 0 0", m0_rdone, m1_seen);
        end
        $display("txn single_read: m0 byte read data=%h", m0_rdata);
    endtask

    task automatic test_rr_write();
        logic [15:0] ord;
        int          nd;
        int          base;
        ord  = '0;
        nd   = 0;
        base = wlog_n;
        m0_wsize   = SZ_WORD;
        m1_wsize   = SZ_WORD;
        m0_wdata   = 32'hDEAD_BEEF;
        m1_wdata   = 32'h1234_5678;
        m0_wenable = 1'b1;
        m1_wenable = 1'b1;
        tick();
        m0_wenable = 1'b0;
        m1_wenable = 1'b0;
        m0_wdata   = 32'h0;
        m1_wdata   = 32'h0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (m0_wdone === 1'b1) begin ord = {ord[14:0], 1'b0}; nd++; end
            if (m1_wdone === 1'b1) begin ord = {ord[14:0], 1'b1}; nd++; end
        end
        checks++;
        if (nd !== 2 || ord !== 16'h0001) begin
            failures++;
            $display("FAIL rr_done_order: got n=%0d order=%b expected n=2 order=01", nd, ord[1:0]);
        end
        checks++;
        if (wlog_n - base !== 2) begin
            failures++;
            $display("FAIL rr_issue_count: got %0d expected 2", wlog_n - base);
        end else begin
            checks++;
            if (wlog_data[base] !== 32'hDEAD_BEEF || wlog_size[base] !== SZ_WORD) begin
                failures++;
                $display("FAIL rr_first: got %h/%b expected deadbeef/11", wlog_data[base], wlog_size[base]);
            end
            checks++;
            if (wlog_data[base+1] !== 32'h1234_5678 || wlog_size[base+1] !== SZ_WORD) begin
                failures++;
                $display("FAIL rr_second: got %h/%b expected 12345678/11", wlog_data[base+1], wlog_size[base+1]);
            end
        end
        $display("txn rr_write: m0 then m1 word writes issued=%0d", wlog_n - base);
    endtask

    task automatic test_stall_read();
        int base;
        int size_bad;
        int wd0;
        int rd1;
        base      = wlog_n;
        size_bad  = 0;
        wd0       = 0;
        rd1       = 0;
        rd_manual = 1'b1;
        m1_rsize   = SZ_WORD;
        m1_renable = 1'b1;
        tick();
        m1_renable = 1'b0;
        tick();
        m0_wsize   = SZ_BYTE;
        m0_wdata   = 32'h0000_00A5;
        m0_wenable = 1'b1;
        tick();
        m0_wenable = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (buf_rsize !== SZ_WORD) size_bad++;
            if (m0_wdone === 1'b1) wd0++;
            if (m1_rdone === 1'b1) rd1++;
        end
        checks++;
        if (size_bad !== 0) begin
            failures++;
            $display("FAIL stall_rsize: got %0d unstable cycles expected 0", size_bad);
        end
        checks++;
        if (wd0 !== 1 || rd1 !== 0) begin
            failures++;
            $display("FAIL stall_dones: got wdone=%0d rdone=%0d expected 1 0", wd0, rd1);
        end
        checks++;
        if (wlog_n - base !== 1 || wlog_data[base] !== 32'h0000_00A5 || wlog_size[base] !== SZ_BYTE) begin
            failures++;
            $display("FAIL stall_write: got n=%0d data=%h expected 1 000000a5", wlog_n - base, wlog_data[base]);
        end
        rd_ret   = 32'hCAFE_F00D;
        rd_force = 1'b1;
        tick();
        tick();
        checks++;
        if (m1_rdone !== 1'b1 || m1_rdata !== 32'hCAFE_F00D || m0_rdata !== 32'h0000_0041) begin
            failures++;
            $display("FAIL stall_release: got done=%b m1=%h m0=%h expected 1 cafef00d 00000041", m1_rdone, m1_rdata, m0_rdata);
        end
        rd_manual = 1'b0;
        tick();
        $display("txn stall_read: m1 read held 50 cycles, m0 write served");
    endtask

    task automatic test_fixed_prio();
        int         n;
        logic [1:0] exp_done;
        f_m0_renable = 1'b1;
        f_m1_renable = 1'b1;
        tick();
        f_m1_renable = 1'b0;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (f_buf_renable !== 1'b1 && n < 12) begin
                tick();
                n++;
            end
            checks++;
            if (n >= 12) begin
                failures++;
                $display("FAIL fp_grant_timeout: got no enable for grant %0d expected enable", g);
            end
            if (g == 2) f_m0_renable = 1'b0;
            tick();
            f_ret   = 32'(g + 32'h100);
            f_force = 1'b1;
            tick();
            tick();
            exp_done = (g < 3) ? 2'b01 : 2'b10;
            checks++;
            if ({f_m1_rdone, f_m0_rdone} !== exp_done) begin
                failures++;
                $display("FAIL fp_grant%0d: got m1m0=%b expected %b", g, {f_m1_rdone, f_m0_rdone}, exp_done);
            end
            $display("txn fixed_prio: grant %0d m1m0_done=%b", g, {f_m1_rdone, f_m0_rdone});
        end
        checks++;
        if (f_m0_rdata !== 32'h102 || f_m1_rdata !== 32'h103) begin
            failures++;
            $display("FAIL fp_rdata: got %h %h expected 00000102 00000103", f_m0_rdata, f_m1_rdata);
        end
    endtask

    task automatic test_lock();
        logic [15:0] ord;
        logic [15:0] exp_ord;
        int          nd;
        int          ne;
        int          exp_n;
`ifdef UART_ARB_LOCK_EN
        exp_ord = 16'h001E;
        exp_n   = 5;
`else
        exp_ord = 16'h002A;
        exp_n   = 6;
`endif
        ord = '0;
        nd  = 0;
        ne  = 0;
        rd_ret     = 32'h0000_0077;
        m0_rsize   = SZ_BYTE;
        m1_rsize   = SZ_BYTE;
        m1_lock    = 1'b1;
        m1_renable = 1'b1;
        tick();
        m0_renable = 1'b1;
        for (int c = 0; c < 90; c++) begin
            tick();
            if (buf_renable === 1'b1) begin
                ne++;
                if (ne == 4) begin
                    m1_renable = 1'b0;
                    m1_lock    = 1'b0;
                end
                if (ne == 5) m0_renable = 1'b0;
            end
            if (m0_rdone === 1'b1) begin ord = {ord[14:0], 1'b0}; nd++; end
            if (m1_rdone === 1'b1) begin ord = {ord[14:0], 1'b1}; nd++; end
        end
        checks++;
        if (nd !== exp_n || ord !== exp_ord) begin
            failures++;
            $display("FAIL lock_order: got n=%0d order=%b expected n=%0d order=%b", nd, ord[5:0], exp_n, exp_ord[5:0]);
        end
        $display("txn lock: %0d grants order=%b", nd, ord[5:0]);
    endtask

    task automatic test_reset_mid();
        int n;
        rd_manual  = 1'b1;
        m0_rsize   = SZ_WORD;
        m0_renable = 1'b1;
        tick();
        m0_renable = 1'b0;
        n = 0;
        while (buf_renable !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        tick();
        tick();
        checks++;
        if (buf_rsize !== SZ_WORD) begin
            failures++;
            $display("FAIL rstmid_pre: got rsize=%b expected 11", buf_rsize);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({buf_renable, buf_rsize, buf_wenable, buf_wsize} !== 6'b0 || buf_wdata !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_buf: got ctl=%b wdata=%h expected 0 0", {buf_renable, buf_rsize, buf_wenable, buf_wsize}, buf_wdata);
        end
        checks++;
        if ({m0_rdata, m1_rdata} !== 64'h0 || {m0_rdone, m1_rdone, m0_wdone, m1_wdone} !== 4'b0) begin
            failures++;
            $display("FAIL rstmid_master: got rdata=%h done=%b expected 0 0", {m0_rdata, m1_rdata}, {m0_rdone, m1_rdone, m0_wdone, m1_wdone});
        end
        tick();
        tick();
        rstn      = 1'b1;
        rd_manual = 1'b0;
        rd_ret    = 32'h0000_005A;
        tick();
        m1_rsize   = SZ_BYTE;
        m1_renable = 1'b1;
        tick();
        m1_renable = 1'b0;
        n = 0;
        while (m1_rdone !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 5 || m1_rdata !== 32'h0000_005A) begin
            failures++;
            $display("FAIL rstmid_after: got n=%0d data=%h expected 5 0000005a", n, m1_rdata);
        end
        $display("txn reset_mid: post-reset m1 read data=%h", m1_rdata);
    endtask

    initial begin
        checks = 0; failures = 0;
        rstn = 1'b0;
        m0_renable = 1'b0; m1_renable = 1'b0;
        m0_rsize = SZ_BYTE; m1_rsize = SZ_BYTE;
        m0_wenable = 1'b0; m1_wenable = 1'b0;
        m0_wsize = SZ_BYTE; m1_wsize = SZ_BYTE;
        m0_wdata = '0; m1_wdata = '0;
        m0_lock = 1'b0; m1_lock = 1'b0;
        buf_rdata = '0; buf_rdone = 1'b0; buf_wdone = 1'b0;
        f_m0_renable = 1'b0; f_m1_renable = 1'b0;
        f_buf_rdata = '0; f_buf_rdone = 1'b0; f_force = 1'b0; f_ret = '0;
        rd_lat = 3; wr_lat = 2; rd_cnt = 0; wr_cnt = 0;
        rd_manual = 1'b0; rd_force = 1'b0; rd_ret = '0; wlog_n = 0;

        test_reset();
        test_single_read();
        test_rr_write();
        test_stall_read();
        test_fixed_prio();
        test_lock();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
